// File: rtl/mem_bus_responder.sv
// Word-organised SRAM responder for the core's mem_valid/mem_ready bus, with byte-lane writes,
// programmable wait states and an optional window check (MEM_BUS_RESPONDER_FAULT_EN).
module mem_bus_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int unsigned SIZE_WORDS  = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        access_fault
);

  localparam int unsigned AW       = $clog2(SIZE_WORDS);
  localparam logic [3:0]  WaitLoad = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          in_win_q, in_win_d;
  logic          ready_q, ready_d;
  logic          fault_q, fault_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [31:0]   mem_q [SIZE_WORDS];

  logic [AW-1:0] in_idx;
  logic          in_win;

`ifdef MEM_BUS_RESPONDER_FAULT_EN
  // Unsigned wrap makes addresses below the base land far above the window.
  logic [31:0] offset;
  assign offset = mem_addr - ADDR_BASE;
  assign in_idx = offset[AW+1:2];
  assign in_win = (offset < 32'(SIZE_WORDS * 4));
`else
  logic unused_addr;
  assign in_idx      = mem_addr[AW+1:2];
  assign in_win      = 1'b1;
  assign unused_addr = ^{mem_addr[31:AW+2], mem_addr[1:0], ADDR_BASE};
`endif

  // With no wait states RESP is entered on the accepting edge, so use the live request there.
  logic          from_idle;
  logic [AW-1:0] req_idx;
  logic [3:0]    req_wstrb;
  logic [31:0]   req_wdata;
  logic          req_in_win;
  logic          resp_entry;
  logic          mem_we;

  assign from_idle  = (state_q == StIdle);
  assign req_idx    = from_idle ? in_idx    : idx_q;
  assign req_wstrb  = from_idle ? mem_wstrb : wstrb_q;
  assign req_wdata  = from_idle ? mem_wdata : wdata_q;
  assign req_in_win = from_idle ? in_win    : in_win_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wstrb_d    = wstrb_q;
    wdata_d    = wdata_q;
    in_win_d   = in_win_q;
    resp_entry = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_valid) begin
          idx_d    = in_idx;
          wstrb_d  = mem_wstrb;
          wdata_d  = mem_wdata;
          in_win_d = in_win;
          if (WAIT_STATES > 0) begin
            state_d = StWait;
            cnt_d   = WaitLoad;
          end else begin
            state_d    = StResp;
            resp_entry = 1'b1;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d    = StResp;
          resp_entry = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ready_d = 1'b0;
    fault_d = 1'b0;
    rdata_d = rdata_q;
    if (resp_entry) begin
      ready_d = 1'b1;
      if (req_in_win) begin
        rdata_d = (req_wstrb == 4'b0000) ? mem_q[req_idx] : 32'h0;
      end else begin
        rdata_d = 32'h0;
        fault_d = 1'b1;
      end
    end
  end

  assign mem_we = resp_entry && req_in_win && (req_wstrb != 4'b0000);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      idx_q    <= '0;
      wstrb_q  <= 4'b0000;
      wdata_q  <= 32'h0;
      in_win_q <= 1'b0;
      ready_q  <= 1'b0;
      fault_q  <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      wstrb_q  <= wstrb_d;
      wdata_q  <= wdata_d;
      in_win_q <= in_win_d;
      ready_q  <= ready_d;
      fault_q  <= fault_d;
      rdata_q  <= rdata_d;
    end
  end

  // Storage is deliberately not reset so contents survive a resetn pulse.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (req_wstrb[i]) begin
          mem_q[req_idx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  assign mem_ready    = ready_q;
  assign access_fault = fault_q;
  assign mem_rdata    = rdata_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench: three responders (0, 3 and 4 wait states) on one clock, checked against
// hand-computed values; covers MEM_BUS_RESPONDER_FAULT_EN either way.
module tb_mem_bus_responder;

  localparam logic [31:0] Base  = 32'h0000_1000;
  localparam int unsigned Words = 16;

  logic        clk = 1'b0;
  logic [2:0]  rst_n;
  logic [2:0]  valid;
  logic [2:0]  ready;
  logic [2:0]  fault;
  logic [3:0]  wstrb [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];

  int n_pass   = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_bus_responder #(
      .ADDR_BASE  (Base),
      .SIZE_WORDS (Words),
      .WAIT_STATES((g == 0) ? 0 : (g == 1) ? 3 : 4)
    ) u_dut (
      .clk         (clk),
      .resetn      (rst_n[g]),
      .mem_valid   (valid[g]),
      .mem_ready   (ready[g]),
      .mem_wstrb   (wstrb[g]),
      .mem_addr    (addr[g]),
      .mem_wdata   (wdata[g]),
      .mem_rdata   (rdata[g]),
      .access_fault(fault[g])
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // lat counts falling edges after the accepting edge until mem_ready is seen.
  task automatic xfer(input int d, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] w, output logic [31:0] rd, output logic flt,
                      output int lat);
    @(negedge clk);
    valid[d] = 1'b1;
    addr[d]  = a;
    wstrb[d] = s;
    wdata[d] = w;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (ready[d] !== 1'b1 && lat < 40);
    rd       = rdata[d];
    flt      = fault[d];
    valid[d] = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        flt;
    int          lat;
    int          p1;
    int          p2;
    int          seen;

    rst_n = 3'b000;
    valid = 3'b000;
    for (int i = 0; i < 3; i++) begin
      wstrb[i] = 4'b0000;
      addr[i]  = 32'h0;
      wdata[i] = 32'h0;
    end
    repeat (2) @(negedge clk);
    rst_n = 3'b111;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_eq("reset_ready", 32'(ready[i]), 32'h0);
      check_eq("reset_fault", 32'(fault[i]), 32'h0);
      check_eq("reset_rdata", rdata[i], 32'h0);
    end

    // Zero wait states: preload then read word 3
    xfer(0, Base + 32'd12, 4'b1111, 32'hDEAD_BEEF, rd, flt, lat);
    check_eq("w0_write_rdata", rd, 32'h0);
    xfer(0, Base + 32'd12, 4'b0000, 32'h0, rd, flt, lat);
    check_eq("w0_read_lat", 32'(lat), 32'd1);
    check_eq("w0_read_data", rd, 32'hDEAD_BEEF);
    check_eq("w0_read_fault", 32'(flt), 32'h0);
    @(negedge clk);
    check_eq("w0_ready_pulse", 32'(ready[0]), 32'h0);
    check_eq("w0_rdata_hold", rdata[0], 32'hDEAD_BEEF);

    // Byte lanes on word 5
    xfer(0, Base + 32'd20, 4'b1111, 32'h1122_3344, rd, flt, lat);
    xfer(0, Base + 32'd20, 4'b0101, 32'hAABB_CCDD, rd, flt, lat);
    xfer(0, Base + 32'd20, 4'b0000, 32'h0, rd, flt, lat);
    check_eq("lane_merge", rd, 32'h11BB_33DD);

    // Three wait states
    xfer(1, Base + 32'd4, 4'b1111, 32'h600D_F00D, rd, flt, lat);
    check_eq("w3_write_lat", 32'(lat), 32'd4);
    xfer(1, Base + 32'd4, 4'b0000, 32'h0, rd, flt, lat);
    check_eq("w3_read_lat", 32'(lat), 32'd4);
    check_eq("w3_read_data", rd, 32'h600D_F00D);
    @(negedge clk);
    check_eq("w3_ready_pulse", 32'(ready[1]), 32'h0);

    // Back-to-back reads with mem_valid held high
    @(negedge clk);
    valid[1] = 1'b1;
    addr[1]  = Base + 32'd4;
    wstrb[1] = 4'b0000;
    p1 = -1;
    p2 = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (ready[1] === 1'b1) begin
        if (p1 < 0) p1 = c;
        else if (p2 < 0) p2 = c;
      end
    end
    valid[1] = 1'b0;
    check_eq("b2b_first", 32'(p1), 32'd4);
    check_eq("b2b_period", 32'(p2 - p1), 32'd5);
    repeat (10) @(negedge clk);

`ifdef MEM_BUS_RESPONDER_FAULT_EN
    xfer(0, Base, 4'b1111, 32'h1234_5678, rd, flt, lat);
    xfer(0, Base + Words * 4, 4'b1111, 32'hFFFF_FFFF, rd, flt, lat);
    check_eq("oow_write_fault", 32'(flt), 32'h1);
    check_eq("oow_write_rdata", rd, 32'h0);
    @(negedge clk);
    check_eq("oow_fault_clear", 32'(fault[0]), 32'h0);
    xfer(0, Base, 4'b0000, 32'h0, rd, flt, lat);
    check_eq("oow_word0_kept", rd, 32'h1234_5678);
    check_eq("oow_word0_fault", 32'(flt), 32'h0);
    xfer(0, Base - 32'd4, 4'b0000, 32'h0, rd, flt, lat);
    check_eq("below_base_fault", 32'(flt), 32'h1);
    check_eq("below_base_rdata", rd, 32'h0);
`else
    xfer(0, Base + Words * 4 + 32'd8, 4'b1111, 32'h0000_00A5, rd, flt, lat);
    check_eq("alias_write_fault", 32'(flt), 32'h0);
    xfer(0, Base + 32'd8, 4'b0000, 32'h0, rd, flt, lat);
    check_eq("alias_read_data", rd, 32'h0000_00A5);
    check_eq("alias_read_fault", 32'(flt), 32'h0);
`endif

    // Reset pulsed while a write sits in WAIT
    xfer(2, Base + 32'd28, 4'b1111, 32'h0, rd, flt, lat);
    check_eq("w4_write_lat", 32'(lat), 32'd5);
    @(negedge clk);
    valid[2] = 1'b1;
    addr[2]  = Base + 32'd28;
    wstrb[2] = 4'b1111;
    wdata[2] = 32'h5555_5555;
    @(negedge clk);
    seen = 0;
    if (ready[2] === 1'b1) seen++;
    rst_n[2] = 1'b0;
    valid[2] = 1'b0;
    @(negedge clk);
    rst_n[2] = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (ready[2] === 1'b1) seen++;
    end
    check_eq("rst_no_ready", 32'(seen), 32'd0);
    xfer(2, Base + 32'd28, 4'b0000, 32'h0, rd, flt, lat);
    check_eq("rst_idle_lat", 32'(lat), 32'd5);
    check_eq("rst_write_dropped", rd, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
